// File: rtl/decode_8b10b_rx_pkg.sv
// Shared constants and types for the 8b/10b receive path: comma codewords,
// alignment states, disparity classes and a small popcount helper.
package decode_8b10b_rx_pkg;

    // Words are held in transmit layout {fghj, abcdei}.
    localparam logic [9:0] COMMA_POSTV = 10'b1010_001111;
    localparam logic [9:0] COMMA_NEGTV = 10'b0101_110000;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } align_state_t;

    typedef enum logic [1:0] {
        DISP_ZERO = 2'b00,
        DISP_POS  = 2'b01,
        DISP_BAD  = 2'b10,
        DISP_NEG  = 2'b11
    } disp_class_t;

    function automatic logic [3:0] count_ones(input logic [9:0] w);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 10; i++) n = n + {3'b000, w[i]};
        return n;
    endfunction

endpackage

// File: rtl/decode_8b10b_lut.sv
// Combinational 10b->8b reverse lookup: decodes a {fghj, abcdei} word into
// a byte, flags commas and legal codes, and classifies word disparity.
module decode_8b10b_lut
    import decode_8b10b_rx_pkg::*;
(
    input  logic [9:0] word,
    output logic [7:0] data,
    output logic       is_comma,
    output logic       code_ok,
    output logic [1:0] disp_class
);

    logic [4:0] d5;
    logic [2:0] d3;
    logic       ok6;
    logic       ok4;

    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        d5  = '0;
        ok6 = 1'b1;
        case (word[5:0])
            6'b100111, 6'b011000: d5 = 5'd0;
            6'b011101, 6'b100010: d5 = 5'd1;
            6'b101101, 6'b010010: d5 = 5'd2;
            6'b110001:            d5 = 5'd3;
            6'b110101, 6'b001010: d5 = 5'd4;
            6'b101001:            d5 = 5'd5;
            6'b011001:            d5 = 5'd6;
            6'b111000, 6'b000111: d5 = 5'd7;
            6'b111001, 6'b000110: d5 = 5'd8;
            6'b100101:            d5 = 5'd9;
            6'b010101:            d5 = 5'd10;
            6'b110100:            d5 = 5'd11;
            6'b001101:            d5 = 5'd12;
            6'b101100:            d5 = 5'd13;
            6'b011100:            d5 = 5'd14;
            6'b010111, 6'b101000: d5 = 5'd15;
            6'b011011, 6'b100100: d5 = 5'd16;
            6'b100011:            d5 = 5'd17;
            6'b010011:            d5 = 5'd18;
            6'b110010:            d5 = 5'd19;
            6'b001011:            d5 = 5'd20;
            6'b101010:            d5 = 5'd21;
            6'b011010:            d5 = 5'd22;
            6'b111010, 6'b000101: d5 = 5'd23;
            6'b110011, 6'b001100: d5 = 5'd24;
            6'b100110:            d5 = 5'd25;
            6'b010110:            d5 = 5'd26;
            6'b110110, 6'b001001: d5 = 5'd27;
            6'b001110:            d5 = 5'd28;
            6'b101110, 6'b010001: d5 = 5'd29;
            6'b011110, 6'b100001: d5 = 5'd30;
            6'b101011, 6'b010100: d5 = 5'd31;
            default:              ok6 = 1'b0;
        endcase
    end

    // Both primary and alternate x.7 encodings map to 7.
    always_comb begin
        d3  = '0;
        ok4 = 1'b1;
        case (word[9:6])
            4'b1011, 4'b0100:                   d3 = 3'd0;
            4'b1001:                            d3 = 3'd1;
            4'b0101:                            d3 = 3'd2;
            4'b1100, 4'b0011:                   d3 = 3'd3;
            4'b1101, 4'b0010:                   d3 = 3'd4;
            4'b1010:                            d3 = 3'd5;
            4'b0110:                            d3 = 3'd6;
            4'b1110, 4'b0001, 4'b0111, 4'b1000: d3 = 3'd7;
            default:                            ok4 = 1'b0;
        endcase
    end

    always_comb begin
        case (count_ones(word))
            4'd4:    disp_class = DISP_NEG;
            4'd5:    disp_class = DISP_ZERO;
            4'd6:    disp_class = DISP_POS;
            default: disp_class = DISP_BAD;
        endcase
    end

    assign data     = {d3, d5};
    assign is_comma = (word == COMMA_POSTV) || (word == COMMA_NEGTV);
    assign code_ok  = ok6 && ok4 && (disp_class != DISP_BAD);

endmodule

// File: rtl/decode_8b10b_rx.sv
// 8b/10b receiver: comma hunt, word alignment lock, decode, running-disparity
// checking and a saturating link error counter.
module decode_8b10b_rx
    import decode_8b10b_rx_pkg::*;
#(
    parameter int LOCK_COMMAS = 2,
    parameter int UNLOCK_ERRS = 4,
    parameter int ERRCNT_W    = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                bit_in,
    input  logic                bit_valid,
    output logic [7:0]          data_out,
    output logic                data_valid,
    output logic                idle_out,
    output logic                code_err,
    output logic                disp_err,
    output logic                locked,
    output logic [ERRCNT_W-1:0] err_count,
    input  logic                err_clr
);

    localparam int CCNT_W = $clog2(LOCK_COMMAS + 1);
    localparam int ECNT_W = $clog2(UNLOCK_ERRS + 1);
    localparam logic [CCNT_W-1:0] LOCK_LAST   = CCNT_W'(LOCK_COMMAS - 1);
    localparam logic [ECNT_W-1:0] UNLOCK_LAST = ECNT_W'(UNLOCK_ERRS - 1);

    align_state_t      state;
    logic [8:0]        window;      // last nine bits; the incoming bit completes the word
    logic [9:0]        window_nxt;
    logic [3:0]        bit_cnt;
    logic [CCNT_W-1:0] comma_cnt;
    logic [ECNT_W-1:0] consec_err;
    logic              rd;

    logic [7:0]        lut_data;
    logic              lut_comma;
    logic              lut_ok;
    logic [1:0]        lut_disp;

    logic              boundary;
    logic              rd_nxt;
    logic              word_disp_err;
    logic              word_bad;
    logic              lock_err;

    assign window_nxt = {window, bit_in};
    assign boundary   = (bit_cnt == 4'd9);

    decode_8b10b_lut u_lut (
        .word       (window_nxt),
        .data       (lut_data),
        .is_comma   (lut_comma),
        .code_ok    (lut_ok),
        .disp_class (lut_disp)
    );

    // A wrong-sign word still resynchronises rd to the sign it carried.
    always_comb begin
        rd_nxt        = rd;
        word_disp_err = 1'b0;
        if (lut_comma) begin
            rd_nxt = (window_nxt == COMMA_POSTV);
        end else if (lut_ok) begin
            case (disp_class_t'(lut_disp))
                DISP_POS: begin rd_nxt = 1'b1; word_disp_err = rd;  end
                DISP_NEG: begin rd_nxt = 1'b0; word_disp_err = ~rd; end
                default:  ;
            endcase
        end
    end

    assign word_bad = !lut_comma && (!lut_ok || word_disp_err);
    // In LOCKED a comma off the word boundary counts as a bad word, not a realignment.
    assign lock_err = bit_valid && (state == LOCKED) && (boundary ? word_bad : lut_comma);

    assign locked = (state == LOCKED);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= HUNT;
            window     <= '0;
            bit_cnt    <= '0;
            comma_cnt  <= '0;
            consec_err <= '0;
            rd         <= 1'b0;
            data_out   <= '0;
            data_valid <= 1'b0;
            idle_out   <= 1'b0;
            code_err   <= 1'b0;
            disp_err   <= 1'b0;
            err_count  <= '0;
        end else begin
            data_valid <= 1'b0;
            idle_out   <= 1'b0;
            code_err   <= 1'b0;
            disp_err   <= 1'b0;

            if (err_clr)
                err_count <= '0;
            else if (lock_err && (err_count != '1))
                err_count <= err_count + 1'b1;

            if (bit_valid) begin
                window  <= window_nxt[8:0];
                bit_cnt <= boundary ? 4'd0 : bit_cnt + 4'd1;

                case (state)
                    HUNT: begin
                        if (lut_comma) begin
                            bit_cnt    <= 4'd0;
                            comma_cnt  <= CCNT_W'(1);
                            rd         <= rd_nxt;
                            consec_err <= '0;
                            state      <= (LOCK_COMMAS <= 1) ? LOCKED : VERIFY;
                        end
                    end
                    VERIFY: begin
                        if (boundary) begin
                            if (lut_comma) begin
                                idle_out  <= 1'b1;
                                rd        <= rd_nxt;
                                comma_cnt <= comma_cnt + 1'b1;
                                if (comma_cnt == LOCK_LAST) state <= LOCKED;
                            end else if (word_bad) begin
                                state <= HUNT;
                            end else begin
                                rd <= rd_nxt;
                            end
                        end
                    end
                    LOCKED: begin
                        if (boundary && lut_comma) begin
                            idle_out <= 1'b1;
                            rd       <= rd_nxt;
                        end else if (boundary && !lut_ok) begin
                            code_err <= 1'b1;
                        end else if (boundary) begin
                            data_valid <= 1'b1;
                            disp_err   <= word_disp_err;
                            data_out   <= lut_data;
                            rd         <= rd_nxt;
                        end else if (lut_comma) begin
                            code_err <= 1'b1;
                        end

                        if (lock_err) begin
                            consec_err <= consec_err + 1'b1;
                            if (consec_err == UNLOCK_LAST) state <= HUNT;
                        end else if (boundary) begin
                            consec_err <= '0;
                        end
                    end
                    default: state <= HUNT;
                endcase
            end
        end
    end

endmodule
